rx_sts_cfo_estimator: RTL and testbench
=======================================

Name: rx_sts_cfo_estimator

Overview:
- Upstream neighbour of the coarse-CFO correction stage in the 802.11a receive chain.
- Computes the lag-16 short-training autocorrelation sum, acc = Σ s[n]·conj(s[n−LAG]), over ACC_LEN samples after packet detection.
- Drives sts_coarse_freq_offset_i/q/valid on the correction stage, which applies arctan, DDS and complex multiply to that vector.
- Only the angle of the output vector matters downstream; magnitude is free scaling.

Parameters:
- LAG, 16, autocorrelation lag in samples (one STS period).
- ACC_LEN, 64, number of lagged products accumulated per estimate (1..144).
- OUT_SHIFT, 8, arithmetic right shift applied to the accumulator before output saturation.
- ACC_WIDTH, 48, accumulator width in bits, signed.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  block enable; low = synchronous clear of all state.
- sample_in_i  in  16  received I, signed two's complement.
- sample_in_q  in  16  received Q, signed.
- sample_in_valid  in  1  sample strobe; gaps allowed.
- pkt_detect  in  1  one-cycle pulse from packet detection.
- sts_coarse_freq_offset_i  out  32  saturated Re(acc), signed.
- sts_coarse_freq_offset_q  out  32  saturated Im(acc), signed.
- sts_coarse_freq_offset_valid  out  1  one-cycle pulse when a new estimate is present.

Behaviour:
- Reset (async, rst=1): all outputs 0, FSM IDLE, accumulator 0, fill and sample counters 0, delay line contents don't-care.
- enable=0: synchronously forces the same state as reset on the next edge.
- Delay line:
  - LAG-deep shift of {q,i}, advanced only on sample_in_valid.
  - fill counter saturates at LAG; "filled" means LAG valid samples have been taken since enable rose.
- Lagged product per accepted sample, current a and delayed b:
  - re = a_i·b_i + a_q·b_q
  - im = a_q·b_i − a_i·b_q
  - each partial is a 32-bit signed product; sums are 33-bit signed.
- Pipeline, for a sample accepted at cycle t:
  - t+1: four products registered.
  - t+2: re/im registered.
  - t+3: accumulator updated (sign-extended add to ACC_WIDTH).
  - t+4: output registered.
  - Output valid therefore rises 4 cycles after the sample_in_valid cycle of the ACC_LEN-th counted sample.
- FSM states:
  - IDLE: entered on reset, enable=0, or enable rising. Next cycle goes to ARMED.
  - ARMED: waits for pkt_detect=1, then goes to ACCUM, clears the accumulator and zeroes the sample counter.
  - ACCUM: a sample counts only if sample_in_valid=1, the cycle is strictly after the pkt_detect cycle, and the line is filled. Unfilled samples are skipped and do not increment the counter. When the counter reaches ACC_LEN, stop counting and go to FLUSH.
  - FLUSH: waits for the pipeline to drain, then drives the valid pulse. Next cycle goes to ARMED.
- Output word: sat32(acc >>> OUT_SHIFT), clamped to [−2^31, 2^31−1]. Data holds its last value between pulses; the valid pulse is exactly one cycle.
- pkt_detect while in ACCUM/FLUSH is ignored: no restart and no extra pulse.
- pkt_detect coincident with enable rising is ignored, because the FSM is still in IDLE.
- sample_in_valid gaps stall counting only; the result is identical to the gapless case.
- rst mid-ACCUM: the estimate is aborted, no pulse is issued, and the line must refill after release.

Test Plan:
- Sample sequence: enable=1, 32 samples of (16384,0), then pkt_detect pulse, then continuous (16384,0).
  - Required: one valid pulse 4 cycles after the 64th post-detect sample.
  - Required data: i=67108864, q=0.
- Sample sequence: blockwise phase rotation; 16-sample blocks cycling (16384,0), (0,16384), (−16384,0), (0,−16384), detect after 32 samples.
  - Required data: i=0, q=67108864, exact.
  - With the block order reversed, required q=−67108864.
- Sample sequence: same as the first scenario, with a sample_in_valid low cycle inserted between every sample.
  - Required: same values; the pulse comes 4 cycles after the 64th valid sample.
- Sample sequence: pkt_detect after only 5 samples post-enable.
  - Required: accumulation starts at the 17th sample; 64 products are still counted; the first-scenario values are obtained.
- Sample sequence: OUT_SHIFT=0, constant (32767,32767).
  - Each re = 2147352578; the sum overflows 32 bits.
  - Required: i=2147483647, q=0.
- Sample sequence: rst asserted at the 30th ACCUM sample, released, new 16 fill samples plus detect.
  - Required: no pulse from the aborted run; outputs 0 during reset; the next estimate is correct.
  - Also: a second pkt_detect inside ACCUM produces exactly one pulse.

Source files
------------

// File: rtl/rx_sts_cfo_estimator.sv
// Coarse CFO estimator: accumulates the lag-LAG short-training autocorrelation over ACC_LEN
// samples after packet detection and emits the saturated, scaled complex sum.
module rx_sts_cfo_estimator #(
  parameter int unsigned LAG       = 16,
  parameter int unsigned ACC_LEN   = 64,
  parameter int unsigned OUT_SHIFT = 8,
  parameter int unsigned ACC_WIDTH = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] sample_in_i,
  input  logic [15:0] sample_in_q,
  input  logic        sample_in_valid,
  input  logic        pkt_detect,
  output logic [31:0] sts_coarse_freq_offset_i,
  output logic [31:0] sts_coarse_freq_offset_q,
  output logic        sts_coarse_freq_offset_valid
);

  localparam int unsigned FillW = $clog2(LAG + 1);
  localparam int unsigned CntW  = $clog2(ACC_LEN + 1);

  typedef enum logic [1:0] {StIdle, StArmed, StAccum, StFlush} state_e;

  state_e state_q, state_d;

  logic [31:0]      line_q [LAG];
  logic [FillW-1:0] fill_q;
  logic [CntW-1:0]  cnt_q;
  logic             filled;
  logic             take;
  logic             last;
  logic             start;

  logic signed [15:0] a_i, a_q, b_i, b_q;

  logic signed [31:0] p_ii_q, p_qq_q, p_qi_q, p_iq_q;
  logic               v1_q, last1_q;
  logic signed [32:0] re_q, im_q;
  logic               v2_q, last2_q;
  logic signed [ACC_WIDTH-1:0] acc_re_q, acc_im_q;
  logic               last3_q;

  logic [31:0] out_i_q, out_q_q;
  logic        out_valid_q;

  assign a_i = sample_in_i;
  assign a_q = sample_in_q;
  assign b_i = line_q[LAG-1][15:0];
  assign b_q = line_q[LAG-1][31:16];

  assign filled = (fill_q == FillW'(LAG));
  assign take   = (state_q == StAccum) && sample_in_valid && filled;
  assign last   = take && (cnt_q == CntW'(ACC_LEN - 1));
  assign start  = (state_q == StArmed) && pkt_detect;

  // Contents are don't-care until fill_q reaches LAG, so no reset is needed.
  always_ff @(posedge clk) begin
    if (sample_in_valid) begin
      line_q[0] <= {sample_in_q, sample_in_i};
      for (int unsigned k = 1; k < LAG; k++) begin
        line_q[k] <= line_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q <= '0;
    end else if (!enable) begin
      fill_q <= '0;
    end else if (sample_in_valid && !filled) begin
      fill_q <= fill_q + FillW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else if (!enable) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cnt_q <= '0;
      end else if (take) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StArmed;
      StArmed: if (pkt_detect) state_d = StAccum;
      StAccum: if (last) state_d = StFlush;
      StFlush: if (last3_q) state_d = StArmed;
      default: state_d = StIdle;
    endcase
  end

  // Three-stage product / sum / accumulate pipeline; last* tags mark the final product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_ii_q   <= '0;
      p_qq_q   <= '0;
      p_qi_q   <= '0;
      p_iq_q   <= '0;
      v1_q     <= 1'b0;
      last1_q  <= 1'b0;
      re_q     <= '0;
      im_q     <= '0;
      v2_q     <= 1'b0;
      last2_q  <= 1'b0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      last3_q  <= 1'b0;
    end else if (!enable) begin
      p_ii_q   <= '0;
      p_qq_q   <= '0;
      p_qi_q   <= '0;
      p_iq_q   <= '0;
      v1_q     <= 1'b0;
      last1_q  <= 1'b0;
      re_q     <= '0;
      im_q     <= '0;
      v2_q     <= 1'b0;
      last2_q  <= 1'b0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      last3_q  <= 1'b0;
    end else begin
      v1_q    <= take;
      last1_q <= last;
      if (take) begin
        p_ii_q <= 32'(a_i) * 32'(b_i);
        p_qq_q <= 32'(a_q) * 32'(b_q);
        p_qi_q <= 32'(a_q) * 32'(b_i);
        p_iq_q <= 32'(a_i) * 32'(b_q);
      end
      v2_q    <= v1_q;
      last2_q <= last1_q;
      if (v1_q) begin
        re_q <= 33'(p_ii_q) + 33'(p_qq_q);
        im_q <= 33'(p_qi_q) - 33'(p_iq_q);
      end
      last3_q <= last2_q;
      if (start) begin
        acc_re_q <= '0;
        acc_im_q <= '0;
      end else if (v2_q) begin
        acc_re_q <= acc_re_q + ACC_WIDTH'(re_q);
        acc_im_q <= acc_im_q + ACC_WIDTH'(im_q);
      end
    end
  end

  function automatic logic [31:0] sat32(input logic signed [ACC_WIDTH-1:0] x);
    logic signed [ACC_WIDTH-1:0] s;
    s = x >>> OUT_SHIFT;
    if ((&s[ACC_WIDTH-1:31]) || !(|s[ACC_WIDTH-1:31])) begin
      return s[31:0];
    end else if (s[ACC_WIDTH-1]) begin
      return 32'h8000_0000;
    end else begin
      return 32'h7fff_ffff;
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_valid_q <= 1'b0;
    end else if (!enable) begin
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= last3_q;
      if (last3_q) begin
        out_i_q <= sat32(acc_re_q);
        out_q_q <= sat32(acc_im_q);
      end
    end
  end

  assign sts_coarse_freq_offset_i     = out_i_q;
  assign sts_coarse_freq_offset_q     = out_q_q;
  assign sts_coarse_freq_offset_valid = out_valid_q;

endmodule

// File: tb/tb_rx_sts_cfo_estimator.sv
// Randomised and directed bench for rx_sts_cfo_estimator: two instances (OUT_SHIFT 8 and 0)
// checked every cycle against a sample-history reference model.
module tb_rx_sts_cfo_estimator;

  localparam int LAG     = 16;
  localparam int ACC_LEN = 64;
  localparam longint SMax = 64'sd2147483647;
  localparam longint SMin = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] sample_in_i = '0;
  logic [15:0] sample_in_q = '0;
  logic        sample_in_valid = 1'b0;
  logic        pkt_detect = 1'b0;
  logic [31:0] o8_i, o8_q, o0_i, o0_q;
  logic        o8_v, o0_v;

  always #5 clk = ~clk;

  rx_sts_cfo_estimator #(.LAG(16), .ACC_LEN(64), .OUT_SHIFT(8), .ACC_WIDTH(48)) dut (
    .clk                          (clk),
    .rst                          (rst),
    .enable                       (enable),
    .sample_in_i                  (sample_in_i),
    .sample_in_q                  (sample_in_q),
    .sample_in_valid              (sample_in_valid),
    .pkt_detect                   (pkt_detect),
    .sts_coarse_freq_offset_i     (o8_i),
    .sts_coarse_freq_offset_q     (o8_q),
    .sts_coarse_freq_offset_valid (o8_v)
  );

  rx_sts_cfo_estimator #(.LAG(16), .ACC_LEN(64), .OUT_SHIFT(0), .ACC_WIDTH(48)) dut_s (
    .clk                          (clk),
    .rst                          (rst),
    .enable                       (enable),
    .sample_in_i                  (sample_in_i),
    .sample_in_q                  (sample_in_q),
    .sample_in_valid              (sample_in_valid),
    .pkt_detect                   (pkt_detect),
    .sts_coarse_freq_offset_i     (o0_i),
    .sts_coarse_freq_offset_q     (o0_q),
    .sts_coarse_freq_offset_valid (o0_v)
  );

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;
  int pulses8 = 0;
  int pulse_edge = -1;
  int det_edge = 0;

  // Reference model: history of accepted samples plus a few flags.
  int     hist_i[$];
  int     hist_q[$];
  longint m_re, m_im;
  int     m_cnt;
  int     m_due = -1;
  bit     m_started, m_armed, m_collect;
  int     exp_v;
  int     exp_i8, exp_q8, exp_i0, exp_q0;

  function automatic int sat_shift(input longint x, input int sh);
    longint s;
    s = x >>> sh;
    if (s > SMax) return int'(SMax);
    if (s < SMin) return int'(SMin);
    return int'(s);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    end
  endtask

  always @(posedge clk) begin
    int  ci, cq;
    bit  was_armed;
    edge_n++;
    exp_v = 0;
    if (rst || !enable) begin
      hist_i.delete();
      hist_q.delete();
      m_re = 0; m_im = 0; m_cnt = 0; m_due = -1;
      m_started = 0; m_armed = 0; m_collect = 0;
      exp_i8 = 0; exp_q8 = 0; exp_i0 = 0; exp_q0 = 0;
    end else begin
      ci = int'($signed(sample_in_i));
      cq = int'($signed(sample_in_q));
      was_armed = m_armed;
      if (m_collect && sample_in_valid && hist_i.size() == LAG) begin
        m_re += longint'(ci) * hist_i[0] + longint'(cq) * hist_q[0];
        m_im += longint'(cq) * hist_i[0] - longint'(ci) * hist_q[0];
        m_cnt++;
        if (m_cnt == ACC_LEN) begin
          m_collect = 0;
          m_due = edge_n + 3;
        end
      end
      if (sample_in_valid) begin
        hist_i.push_back(ci);
        hist_q.push_back(cq);
        if (hist_i.size() > LAG) begin
          void'(hist_i.pop_front());
          void'(hist_q.pop_front());
        end
      end
      if (was_armed && pkt_detect) begin
        m_armed = 0; m_collect = 1; m_re = 0; m_im = 0; m_cnt = 0;
      end
      if (!m_started) begin
        m_started = 1;
        m_armed = 1;
      end
      if (edge_n == m_due) begin
        exp_v  = 1;
        exp_i8 = sat_shift(m_re, 8);
        exp_q8 = sat_shift(m_im, 8);
        exp_i0 = sat_shift(m_re, 0);
        exp_q0 = sat_shift(m_im, 0);
        m_due  = -1;
        m_armed = 1;
      end
    end
    #1;
    check("valid_s8", longint'(o8_v), exp_v);
    check("i_s8", longint'($signed(o8_i)), exp_i8);
    check("q_s8", longint'($signed(o8_q)), exp_q8);
    check("valid_s0", longint'(o0_v), exp_v);
    check("i_s0", longint'($signed(o0_i)), exp_i0);
    check("q_s0", longint'($signed(o0_q)), exp_q0);
    if (o8_v) begin
      pulses8++;
      pulse_edge = edge_n;
    end
  end

  task automatic drive(input bit v, input int si, input int sq, input bit det);
    @(negedge clk);
    sample_in_valid = v;
    sample_in_i = 16'(si);
    sample_in_q = 16'(sq);
    pkt_detect = det;
  endtask

  // kind 0: constant, 1: +90 deg per block, 2: -90 deg per block, 3: full-scale constant
  function automatic void samp(input int kind, input int n, output int si, output int sq);
    int ph;
    ph = (n / 16) % 4;
    if (kind == 2) ph = (4 - ph) % 4;
    if (kind == 0) begin
      si = 16384; sq = 0;
    end else if (kind == 3) begin
      si = 32767; sq = 32767;
    end else begin
      case (ph)
        0: begin si = 16384;  sq = 0;      end
        1: begin si = 0;      sq = 16384;  end
        2: begin si = -16384; sq = 0;      end
        default: begin si = 0; sq = -16384; end
      endcase
    end
  endfunction

  task automatic scenario(input int kind, input int n_pre, input bit gaps, input bit det_at_en,
                          input int n_post);
    int si, sq;
    repeat (2) begin
      @(negedge clk);
      enable = 1'b0; sample_in_valid = 1'b0; pkt_detect = 1'b0;
    end
    for (int n = 0; n <= n_pre + n_post; n++) begin
      samp(kind, n, si, sq);
      drive(1'b1, si, sq, (n == n_pre) || (det_at_en && n == 0));
      if (n == 0) enable = 1'b1;
      if (n == n_pre) det_edge = edge_n + 1;
      if (gaps) drive(1'b0, 0, 0, 1'b0);
    end
    repeat (8) drive(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int p0;
    int si, sq;
    repeat (3) @(negedge clk);
    check("reset_i", longint'($signed(o8_i)), 0);
    check("reset_valid", longint'(o8_v), 0);
    rst = 1'b0;

    // Constant input: one pulse 4 cycles after the 64th post-detect sample.
    p0 = pulses8;
    scenario(0, 32, 1'b0, 1'b0, 80);
    check("s1_pulses", pulses8 - p0, 1);
    check("s1_latency", pulse_edge - det_edge, 67);
    check("s1_i", longint'($signed(o8_i)), 67108864);
    check("s1_q", longint'($signed(o8_q)), 0);

    scenario(1, 32, 1'b0, 1'b0, 80);
    check("rot_fwd_i", longint'($signed(o8_i)), 0);
    check("rot_fwd_q", longint'($signed(o8_q)), 67108864);

    scenario(2, 32, 1'b0, 1'b0, 80);
    check("rot_rev_q", longint'($signed(o8_q)), -67108864);

    p0 = pulses8;
    scenario(0, 32, 1'b1, 1'b0, 80);
    check("gaps_pulses", pulses8 - p0, 1);
    check("gaps_i", longint'($signed(o8_i)), 67108864);

    // Early detect, plus a detect coincident with enable rising that must be ignored.
    p0 = pulses8;
    scenario(0, 5, 1'b0, 1'b1, 80);
    check("early_pulses", pulses8 - p0, 1);
    check("early_i", longint'($signed(o8_i)), 67108864);

    scenario(3, 16, 1'b0, 1'b0, 80);
    check("sat_s0_i", longint'($signed(o0_i)), 2147483647);
    check("sat_s0_q", longint'($signed(o0_q)), 0);
    check("sat_s8_i", longint'($signed(o8_i)), 536838144);

    // Reset mid-accumulation, then a clean run with a spurious second detect.
    repeat (2) begin
      @(negedge clk);
      enable = 1'b0; sample_in_valid = 1'b0; pkt_detect = 1'b0;
    end
    p0 = pulses8;
    for (int n = 0; n <= 16 + 30; n++) begin
      drive(1'b1, 16384, 0, n == 16);
      if (n == 0) enable = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async_valid", longint'(o8_v), 0);
    check("rst_async_i", longint'($signed(o8_i)), 0);
    repeat (2) drive(1'b1, 16384, 0, 1'b0);
    rst = 1'b0;
    for (int n = 0; n <= 16 + 80; n++) begin
      drive(1'b1, 16384, 0, (n == 16) || (n == 40));
    end
    repeat (8) drive(1'b0, 0, 0, 1'b0);
    check("rst_pulses", pulses8 - p0, 1);
    check("rst_i", longint'($signed(o8_i)), 67108864);

    // Random traffic with sporadic detects, enable drops and resets.
    p0 = pulses8;
    @(negedge clk);
    enable = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      sample_in_valid = ($urandom_range(9) < 7);
      si = int'($urandom);
      sq = int'($urandom);
      sample_in_i = 16'(si);
      sample_in_q = 16'(sq);
      pkt_detect = ($urandom_range(39) == 0);
      enable = ($urandom_range(499) != 0);
      rst = ($urandom_range(999) == 0);
    end
    rst = 1'b0;
    repeat (8) drive(1'b0, 0, 0, 1'b0);
    check("rand_pulses_seen", longint'(pulses8 > p0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
